// File: rtl/mem_pkg.sv
// Shared types and constants for the RV32I MEM stage.
//   result_src_t : writeback result selector carried through EX/MEM and MEM/WB
//   F3_*         : funct3 access size/sign codes for loads and stores
//   mem_state_t  : MEM-stage bus FSM states
package mem_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   master : MEM stage side (drives request, address, byte enables, write data)
//   slave  : memory side (returns read data and acknowledge)
interface memory_stage_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage.
//   funct3     in  access size/sign code
//   byteOff    in  low two address bits
//   storeData  in  LSB-justified store data
//   readData   in  raw 32-bit word from memory
//   byteEn     out byte enables for the addressed lanes
//   laneData   out store data replicated across lanes
//   loadData   out selected and sign/zero-extended load value
//   misaligned out access crosses its natural alignment
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byteOff,
  input  logic [31:0] storeData,
  input  logic [31:0] readData,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic       isByte;
  logic       isHalf;
  logic [7:0] byteSel;
  logic [15:0] halfSel;

  always_comb begin
    isByte     = (funct3 == F3_B) || (funct3 == F3_BU);
    isHalf     = (funct3 == F3_H) || (funct3 == F3_HU);
    byteSel    = readData[{byteOff, 3'b000} +: 8];
    halfSel    = byteOff[1] ? readData[31:16] : readData[15:0];
    // Anything that is neither byte nor half (incl. undefined codes) is a word.
    misaligned = isHalf ? byteOff[0] : (!isByte && (byteOff != 2'b00));

    byteEn   = 4'b1111;
    laneData = storeData;
    loadData = readData;
    if (isByte) begin
      byteEn   = 4'b0001 << byteOff;
      laneData = {4{storeData[7:0]}};
      loadData = (funct3 == F3_B) ? {{24{byteSel[7]}}, byteSel} : {24'b0, byteSel};
    end else if (isHalf) begin
      byteEn   = 4'b0011 << {byteOff[1], 1'b0};
      laneData = {2{storeData[15:0]}};
      loadData = (funct3 == F3_H) ? {{16{halfSel[15]}}, halfSel} : {16'b0, halfSel};
    end
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: issues loads/stores on a req/ack bus with wait states,
// aligns load data and drives the MEM/WB pipeline register.
//   CLK, RESET            clock, asynchronous active-high reset
//   *M inputs             EX/MEM register fields of the instruction in MEM
//   bus                   data-memory request/acknowledge bus (master side)
//   StallM                holds upstream stages while an access is outstanding
//   MisalignM, BusErrorM  single-cycle fault pulses
//   *W outputs            MEM/WB register fields
module memory_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           Funct3M,
  input  logic [4:0]           RdM,
  input  logic [31:0]          ALUResultM,
  input  logic [31:0]          WriteDataM,
  input  logic [31:0]          PCPlus4M,
  memory_stage_if.master       bus,
  output logic                 StallM,
  output logic                 MisalignM,
  output logic                 BusErrorM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [4:0]           RdW,
  output logic [31:0]          ReadDataW,
  output logic [31:0]          ALUResultW,
  output logic [31:0]          PCPlus4W
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_WAIT  = WAIT;

  logic [0:0]       stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;

  logic        isLoad, access, misaligned, issueNow, inWait, timeoutHit, reqLive, done;
  logic [3:0]  byteEn;
  logic [31:0] laneData, loadData;

  mem_align u_align (
    .funct3     (Funct3M),
    .byteOff    (ALUResultM[1:0]),
    .storeData  (WriteDataM),
    .readData   (bus.mem_rdata),
    .byteEn     (byteEn),
    .laneData   (laneData),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  always_comb begin
    isLoad     = (ResultSrcM == RES_MEM);
    access     = MemWriteM | isLoad;
    inWait     = (stateQ == ST_WAIT);
    issueNow   = (stateQ == ST_IDLE) & access & ~misaligned;
    timeoutHit = inWait & (cntQ == CNT_LAST) & ~bus.mem_ack;
    // Reset gates the combinational request so it drops immediately.
    reqLive    = ~RESET & (issueNow | inWait);
    done       = reqLive & bus.mem_ack;
    StallM     = reqLive & ~bus.mem_ack & ~timeoutHit;
    MisalignM  = ~RESET & (stateQ == ST_IDLE) & access & misaligned;
    BusErrorM  = ~RESET & timeoutHit;

    stateD = stateQ;
    cntD   = '0;
    if (issueNow && !bus.mem_ack) begin
      stateD = ST_WAIT;
    end
    if (inWait) begin
      if (bus.mem_ack || timeoutHit) begin
        stateD = ST_IDLE;
      end else begin
        cntD = cntQ + 1'b1;
      end
    end
  end

  always_comb begin
    bus.mem_req   = reqLive;
    bus.mem_we    = MemWriteM;
    bus.mem_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
    bus.mem_be    = byteEn;
    bus.mem_wdata = laneData;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateQ <= ST_IDLE;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // MEM/WB: a bubble while stalled, otherwise the retiring instruction.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ReadDataW  <= 32'd0;
      ALUResultW <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ReadDataW  <= 32'd0;
      ALUResultW <= 32'd0;
      PCPlus4W   <= 32'd0;
    end else begin
      RegWriteW  <= RegWriteM & ~MisalignM & ~BusErrorM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ReadDataW  <= (done & isLoad) ? loadData : 32'd0;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = 2'b00;
  logic [2:0]  Funct3M = 3'b000;
  logic [4:0]  RdM = 5'd0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic        StallM, MisalignM, BusErrorM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;

  memory_stage_if #(.ADDR_W(32)) bus ();

  memory_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M),
    .bus        (bus),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrorM  (BusErrorM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RdW        (RdW),
    .ReadDataW  (ReadDataW),
    .ALUResultW (ALUResultW),
    .PCPlus4W   (PCPlus4W)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic        req, we, stall, mis, berr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic        full, bubble, chkRead;
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] rdata, alu, pc4;
  } wb_exp_t;

  mem_exp_t memQ[$];
  wb_exp_t  wbQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares everything expected for the current cycle.
  always @(negedge CLK) begin
    mem_exp_t m;
    wb_exp_t  w;
    while (memQ.size() > 0 && memQ[0].cyc <= cyc) begin
      m = memQ.pop_front();
      if (m.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL mem_stale cyc %0d got entry for %0d want none", cyc, m.cyc);
      end else begin
        chk("StallM", 32'(StallM), 32'(m.stall));
        chk("MisalignM", 32'(MisalignM), 32'(m.mis));
        chk("BusErrorM", 32'(BusErrorM), 32'(m.berr));
        chk("mem_req", 32'(bus.mem_req), 32'(m.req));
        if (m.req) begin
          chk("mem_we", 32'(bus.mem_we), 32'(m.we));
          chk("mem_addr", bus.mem_addr, m.addr);
          chk("mem_be", 32'(bus.mem_be), 32'(m.be));
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end
    end
    while (wbQ.size() > 0 && wbQ[0].cyc <= cyc) begin
      w = wbQ.pop_front();
      if (w.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL wb_stale cyc %0d got entry for %0d want none", cyc, w.cyc);
      end else begin
        chk("RegWriteW", 32'(RegWriteW), 32'(w.rw));
        if (w.full || w.bubble) chk("RdW", 32'(RdW), 32'(w.rd));
        if (w.full) begin
          chk("ResultSrcW", 32'(ResultSrcW), 32'(w.rs));
          chk("ALUResultW", ALUResultW, w.alu);
          chk("PCPlus4W", PCPlus4W, w.pc4);
        end
        if (w.chkRead) chk("ReadDataW", ReadDataW, w.rdata);
      end
    end
  end

  // Reference model helpers: plain arithmetic on access size and byte offset.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] lane(input logic [31:0] wd, input int n);
    if (n == 1) return wd[7:0] * 32'h0101_0101;
    if (n == 2) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] rdw, input logic [2:0] f3,
                                           input int off);
    int     n = size_of(f3);
    longint v = longint'({32'b0, rdw});
    v = (v >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic wb_exp_t wb_zero(input int c);
    wb_exp_t w = '{default: 0};
    w.cyc = c;
    w.full = 1'b1;
    w.chkRead = 1'b1;
    return w;
  endfunction

  // Drives one instruction for as many cycles as it occupies MEM; lat is the
  // number of cycles before ack (lat > TIMEOUT means ack is withheld).
  task automatic issue(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4, input int lat,
                       input bit useFix, input logic [31:0] fixRd);
    int          n     = size_of(f3);
    int          off   = int'(alu[1:0]);
    logic        acc   = mw || (rs == 2'b01);
    logic        mis   = acc && ((off % n) != 0);
    logic        go    = acc && !mis;
    logic        abort = go && (lat > TIMEOUT);
    int          ncyc  = !go ? 1 : (abort ? TIMEOUT + 1 : lat + 1);
    logic [31:0] rdv;
    mem_exp_t    m;
    wb_exp_t     w;
    for (int i = 0; i < ncyc; i++) begin
      RegWriteM  = rw;
      MemWriteM  = mw;
      ResultSrcM = rs;
      Funct3M    = f3;
      RdM        = rd;
      ALUResultM = alu;
      WriteDataM = wd;
      PCPlus4M   = pc4;
      rdv = useFix ? fixRd : $urandom;
      bus.mem_rdata = rdv;
      bus.mem_ack   = go ? (i == lat) : 1'($urandom_range(0, 1));

      m.cyc   = cyc;
      m.req   = go;
      m.we    = mw;
      m.addr  = {alu[31:2], 2'b00};
      m.be    = 4'(((1 << n) - 1) << off);
      m.wdata = lane(wd, n);
      m.stall = go && (i < ncyc - 1);
      m.mis   = mis;
      m.berr  = abort && (i == ncyc - 1);
      memQ.push_back(m);

      w = '{default: 0};
      w.cyc = cyc + 1;
      if (i < ncyc - 1) begin
        w.bubble = 1'b1;
      end else begin
        w.rw      = rw && !mis && !abort;
        w.full    = !mis && !abort;
        w.rs      = rs;
        w.rd      = rd;
        w.alu     = alu;
        w.pc4     = pc4;
        w.chkRead = !acc || (go && !abort && !mw);
        w.rdata   = !acc ? 32'd0 : load_val(rdv, f3, off);
      end
      wbQ.push_back(w);
      @(posedge CLK);
      #1;
    end
  endtask

  // LW that never gets an ack; RESET asserted in the second WAIT cycle.
  task automatic reset_mid_wait();
    mem_exp_t m;
    wb_exp_t  w;
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; Funct3M = 3'b010;
    RdM = 5'd7; ALUResultM = 32'h300; WriteDataM = 32'h0; PCPlus4M = 32'h44;
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m = '{default: 0};
      m.cyc = cyc;
      if (i < 2) begin
        m.req = 1'b1; m.stall = 1'b1; m.addr = 32'h300; m.be = 4'hF;
        w = '{default: 0};
        w.cyc = cyc + 1;
        w.bubble = 1'b1;
        wbQ.push_back(w);
      end else begin
        RESET = 1'b1;
        wbQ.push_back(wb_zero(cyc));
      end
      memQ.push_back(m);
      @(posedge CLK);
      #1;
    end
    RESET = 1'b0;
    wbQ.push_back(wb_zero(cyc));
  endtask

  initial begin
    int          kind, lat, r;
    logic [1:0]  rs;
    logic        mw;
    mem_exp_t    m;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    m = '{default: 0};
    m.cyc = cyc;
    memQ.push_back(m);
    wbQ.push_back(wb_zero(cyc));
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    wbQ.push_back(wb_zero(cyc));

    issue(0, 1, 2'b00, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF, 32'h10, 0, 0, 0);
    issue(1, 0, 2'b01, 3'b000, 5'd9, 32'h103, 32'h0, 32'h14, 3, 1, 32'h8011_2233);
    issue(1, 0, 2'b01, 3'b101, 5'd4, 32'h101, 32'h0, 32'h18, 0, 0, 0);
    issue(1, 0, 2'b01, 3'b010, 5'd3, 32'h200, 32'h0, 32'h1C, 100, 0, 0);
    reset_mid_wait();
    issue(1, 0, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h20, 0, 0, 0);
    issue(0, 1, 2'b00, 3'b001, 5'd0, 32'h202, 32'hABCD, 32'h24, 0, 0, 0);
    issue(1, 0, 2'b01, 3'b010, 5'd6, 32'h204, 32'h0, 32'h28, TIMEOUT, 0, 0);
    issue(1, 0, 2'b01, 3'b100, 5'd8, 32'h206, 32'h0, 32'h2C, TIMEOUT - 1, 0, 0);

    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 3);
      mw = (kind == 3);
      rs = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b10 : (kind == 2) ? 2'b01 : 2'b00;
      r = $urandom_range(0, 9);
      lat = (r < 6) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : 0;
      issue(1'($urandom_range(0, 1)), mw, rs, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, lat, 0, 0);
    end

    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; bus.mem_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (memQ.size() != 0 || wbQ.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got %0d/%0d want 0/0", memQ.size(), wbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
